pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_pkg.sv | 12 +
 rtl/ce_div.sv | 23 ++
 rtl/pll_reset_seq.sv | 93 +++++++++
 tb/tb_pll_reset_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  localparam int LOST_W = 8;
  localparam int CNT_W  = 16;
endpackage

// File: rtl/ce_div.sv
// One clock-enable channel: counts 0..D-1 while enabled and strobes on wrap.
module ce_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);
  logic [DIV_W-1:0] cnt;
  logic             wrap;

  // D of 0 or 1 strobes every cycle; a ratio lowered below the count wraps at once.
  assign wrap = (div <= DIV_W'(1)) || (cnt >= div - DIV_W'(1));
  assign ce   = en & wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        cnt <= '0;
    else if (!en || wrap) cnt <= '0;
    else                 cnt <= cnt + DIV_W'(1);
  end
endmodule

// File: rtl/pll_reset_seq.sv
// Sequences downstream reset release after a filtered PLL lock and drives
// per-channel clock enables once running.
module pll_reset_seq
  import pll_pkg::*;
#(
  parameter int LOCK_FILTER = 16,
  parameter int RESET_HOLD  = 32,
  parameter int NUM_CE      = 2,
  parameter int DIV_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    locked,
  input  logic [NUM_CE*DIV_W-1:0] div_ratio,
  output logic                    sys_reset,
  output logic                    ready,
  output logic [NUM_CE-1:0]       ce,
  output logic [LOST_W-1:0]       lost_count
);
  localparam logic [CNT_W-1:0] FILT_END = CNT_W'(LOCK_FILTER);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RESET_HOLD);

  pll_state_t       state;
  logic [1:0]       sync;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;

  assign lock_s = sync[1];

  // sys_reset/ready default to "in reset" and are only released on the
  // paths that land in (or stay in) RUN, so they track the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync       <= '0;
      state      <= WAIT_LOCK;
      cnt        <= '0;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
      lost_count <= '0;
    end else begin
      sync      <= {sync[0], locked};
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      case (state)
        WAIT_LOCK: if (lock_s) begin
          state <= FILTER;
          cnt   <= CNT_W'(1);
        end
        FILTER: if (!lock_s) begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end else if (cnt == FILT_END) begin
          state <= HOLD;
          cnt   <= CNT_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        HOLD: if (!lock_s) begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end else if (cnt == HOLD_END) begin
          state     <= RUN;
          cnt       <= '0;
          sys_reset <= 1'b0;
          ready     <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        RUN: if (!lock_s) begin
          state <= WAIT_LOCK;
          if (lost_count != {LOST_W{1'b1}}) lost_count <= lost_count + LOST_W'(1);
        end else begin
          sys_reset <= 1'b0;
          ready     <= 1'b1;
        end
        default: begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
    ce_div #(.DIV_W(DIV_W)) u_div (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (ready),
      .div     (div_ratio[i*DIV_W +: DIV_W]),
      .ce      (ce[i])
    );
  end
endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed scoreboard bench for pll_reset_seq at default parameters.
module tb_pll_reset_seq;
  localparam int LAT = 51;  // 2 sync + 16 filter + 32 hold + 1

  logic        clk = 1'b0;
  logic        reset_n;
  logic        locked;
  logic [15:0] div_ratio;
  logic        sys_reset, ready;
  logic [1:0]  ce;
  logic [7:0]  lost_count;

  pll_reset_seq #(.LOCK_FILTER(16), .RESET_HOLD(32), .NUM_CE(2), .DIV_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .locked     (locked),
    .div_ratio  (div_ratio),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .ce         (ce),
    .lost_count (lost_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       sr;
    logic [1:0] ce;
    bit         cc;
    logic [7:0] lost;
    bit         cl;
  } exp_t;

  exp_t  sb[$];
  string nmq[$];
  int    n_vec = 0;
  int    n_bad = 0;
  bit    done  = 1'b0;

  // lost < 0 means lost_count is not checked; ready is always expected as ~sr.
  task automatic push(input int c, input string nm, input logic sr,
                      input logic [1:0] cev, input bit cc, input int lost);
    exp_t e;
    e.cyc = c; e.sr = sr; e.ce = cev; e.cc = cc;
    e.lost = (lost < 0) ? 8'd0 : lost[7:0];
    e.cl = (lost >= 0);
    sb.push_back(e);
    nmq.push_back(nm);
  endtask

  task automatic goto(input int c);
    do begin @(posedge clk); #1; end while (cyc < c);
  endtask

  function automatic int sat(input int k);
    return (k > 255) ? 255 : k;
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t  e;
      string nm;
      e  = sb.pop_front();
      nm = nmq.pop_front();
      n_vec++;
      if (e.cyc != cyc || sys_reset !== e.sr || ready !== !e.sr ||
          (e.cc && ce !== e.ce) || (e.cl && lost_count !== e.lost)) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (due %0d): got sys_reset=%b ready=%b ce=%b lost=%0d, want sys_reset=%b ready=%b ce=%b lost=%0d",
                 nm, cyc, e.cyc, sys_reset, ready, ce, lost_count, e.sr, !e.sr, e.ce, e.lost);
      end
    end
    if (done) begin
      while (sb.size() > 0) begin
        string nm;
        void'(sb.pop_front());
        nm = nmq.pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL %s: expectation never reached, got cyc %0d, want earlier cycle", nm, cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout at cyc %0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, r, s, t, u, x;
    reset_n   = 1'b0;
    locked    = 1'b0;
    div_ratio = {8'd3, 8'd1};
    push(2, "reset_vals", 1'b1, 2'b00, 1'b1, 0);
    push(4, "after_release", 1'b1, 2'b00, 1'b1, 0);
    goto(3);
    reset_n = 1'b1;

    // Lock from cold: release after LAT cycles, then ch0 D=1 / ch1 D=3.
    goto(5);
    p = cyc;
    locked = 1'b1;
    push(p + LAT - 1, "hold_end", 1'b1, 2'b00, 1'b1, 0);
    push(p + LAT,     "release",  1'b0, 2'b01, 1'b1, 0);
    push(p + LAT + 1, "ce_run2",  1'b0, 2'b01, 1'b1, 0);
    push(p + LAT + 2, "ce_run3",  1'b0, 2'b11, 1'b1, 0);
    push(p + LAT + 3, "ce_run4",  1'b0, 2'b01, 1'b1, 0);
    push(p + LAT + 4, "ce_run5",  1'b0, 2'b01, 1'b1, 0);
    push(p + LAT + 5, "ce_run6",  1'b0, 2'b11, 1'b1, 0);
    goto(p + LAT + 7);

    // Repeated lock loss in RUN: lost_count saturates, reset reasserts.
    for (int k = 1; k <= 300; k++) begin
      r = cyc;
      locked = 1'b0;
      push(r,     "pre_drop",    1'b0, 2'b00, 1'b0, sat(k - 1));
      push(r + 3, "drop_reset",  1'b1, 2'b00, 1'b1, sat(k));
      goto(r + 3);
      locked = 1'b1;
      push(r + 3 + LAT - 1, "relock_hold", 1'b1, 2'b00, 1'b1, sat(k));
      push(r + 3 + LAT,     "relock_run",  1'b0, 2'b00, 1'b0, sat(k));
      goto(r + 3 + LAT + 2);
    end

    // Async reset mid-RUN, then the full sequence again.
    s = cyc;
    push(s, "async_reset", 1'b1, 2'b00, 1'b1, 0);
    #1 reset_n = 1'b0;
    goto(s + 2);
    reset_n = 1'b1;
    t = cyc;
    push(t + 1,       "rst2_hold",    1'b1, 2'b00, 1'b1, 0);
    push(t + LAT - 1, "rst2_hold_end", 1'b1, 2'b00, 1'b1, 0);
    push(t + LAT,     "rst2_release", 1'b0, 2'b01, 1'b1, 0);
    goto(t + LAT + 3);

    // Glitch at filter count 10: restart, release 51 cycles after re-lock.
    reset_n = 1'b0;
    goto(cyc + 2);
    reset_n   = 1'b1;
    u         = cyc;
    div_ratio = {8'd10, 8'd1};
    goto(u + 10);
    locked = 1'b0;
    goto(u + 11);
    locked = 1'b1;
    x = u + 11 + LAT;
    push(u + 13, "glitch_back", 1'b1, 2'b00, 1'b1, 0);
    push(u + 30, "glitch_lost", 1'b1, 2'b00, 1'b1, 0);
    push(x - 1,  "glitch_hold", 1'b1, 2'b00, 1'b1, 0);
    push(x,      "glitch_rel",  1'b0, 2'b01, 1'b1, 0);
    for (int k = 1; k <= 5; k++) push(x + k, "d10_count", 1'b0, 2'b01, 1'b1, 0);

    // Ratio 10 -> 4 with ch1 counter at 6: wrap next cycle, then every 4.
    goto(x + 6);
    div_ratio = {8'd4, 8'd1};
    push(x + 7,  "d4_c0", 1'b0, 2'b01, 1'b1, 0);
    push(x + 8,  "d4_c1", 1'b0, 2'b01, 1'b1, 0);
    push(x + 9,  "d4_c2", 1'b0, 2'b01, 1'b1, 0);
    push(x + 10, "d4_c3", 1'b0, 2'b11, 1'b1, 0);
    push(x + 11, "d4_c0b", 1'b0, 2'b01, 1'b1, 0);
    push(x + 12, "d4_c1b", 1'b0, 2'b01, 1'b1, 0);
    push(x + 13, "d4_c2b", 1'b0, 2'b01, 1'b1, 0);
    push(x + 14, "d4_c3b", 1'b0, 2'b11, 1'b1, 0);
    goto(x + 16);

    done = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
